// File: rtl/clk_gate_icg.sv
// clk_gate_icg: latch-based glitch-free clock gate with hold-off, scan bypass and gated-edge counter
module clk_gate_icg #(
    parameter int HOLD_CYCLES = 0,
    parameter int HOLD_WIDTH  = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 test_en,
    output logic                 g_clk,
    output logic                 gate_open,
    output logic [CNT_WIDTH-1:0] gated_cnt
);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLD_CYCLES);
    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic                  eff_en;
    logic                  en_lat;
    always_ff @(posedge clk or posedge rst)
        if (rst) hold_cnt <= '0;
        else if (en) hold_cnt <= HOLD_LOAD;
        else if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
    assign eff_en = en | test_en | (hold_cnt != '0);
    always_latch
        if (rst) en_lat <= 1'b0;
        else if (!clk) en_lat <= eff_en;
    assign g_clk     = clk & en_lat;
    assign gate_open = en_lat;
    always_ff @(posedge clk or posedge rst)
        if (rst) gated_cnt <= '0;
        else if (!en_lat && !(&gated_cnt)) gated_cnt <= gated_cnt + CNT_WIDTH'(1);
endmodule

// File: tb/tb_clk_gate_icg.sv
// tb_clk_gate_icg: two gate instances (no hold / 3-cycle hold with 4-bit counter) against an edge-history model
module tb_clk_gate_icg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        test_en = 1'b0;
    logic        g_clk0, open0, g_clk3, open3;
    logic [15:0] cnt0;
    logic [3:0]  cnt3;
    int          checks = 0;
    int          failures = 0;
    int          pc0 = 0, pc3 = 0;
    int          s0, s3, c0s, c3s;
    time         r0, r3;
    int          edge_n = 0, last_en = 0;
    bit          have_en = 0, p0 = 0, p3 = 0;
    int          m0 = 0, m3 = 0;

    always #5 clk = ~clk;

    clk_gate_icg #(.HOLD_CYCLES(0), .HOLD_WIDTH(8), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .en(en), .test_en(test_en),
        .g_clk(g_clk0), .gate_open(open0), .gated_cnt(cnt0));
    clk_gate_icg #(.HOLD_CYCLES(3), .HOLD_WIDTH(2), .CNT_WIDTH(4)) dut3 (
        .clk(clk), .rst(rst), .en(en), .test_en(test_en),
        .g_clk(g_clk3), .gate_open(open3), .gated_cnt(cnt3));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag);
        chk({tag, "_g_clk0"}, longint'(g_clk0), longint'(p0));
        chk({tag, "_open0"}, longint'(open0), longint'(p0));
        chk({tag, "_cnt0"}, longint'(cnt0), longint'(m0));
        chk({tag, "_g_clk3"}, longint'(g_clk3), longint'(p3));
        chk({tag, "_open3"}, longint'(open3), longint'(p3));
        chk({tag, "_cnt3"}, longint'(cnt3), longint'(m3));
    endtask

    task automatic step(input logic a, input logic b);
        @(negedge clk);
        #2;
        en = a;
        test_en = b;
    endtask

    // A pulse is due when en or test_en is up at the edge, or an en edge lies within HOLD_CYCLES behind it.
    always @(posedge clk) begin
        if (rst) begin
            have_en = 0; m0 = 0; m3 = 0; p0 = 0; p3 = 0;
        end else begin
            p0 = en || test_en || (have_en && edge_n - last_en <= 0);
            p3 = en || test_en || (have_en && edge_n - last_en <= 3);
            if (!p0 && m0 < 65535) m0++;
            if (!p3 && m3 < 15) m3++;
            if (en) begin have_en = 1; last_en = edge_n; end
        end
        edge_n++;
        #1 cmp("early");
        #3;
        if (rst) begin
            have_en = 0; m0 = 0; m3 = 0; p0 = 0; p3 = 0;
        end
        cmp("late");
    end

    always @(negedge clk) begin
        #1;
        chk("low_g_clk0", longint'(g_clk0), 0);
        chk("low_g_clk3", longint'(g_clk3), 0);
    end

    always @(posedge g_clk0) begin pc0++; r0 = $time; end
    always @(posedge g_clk3) begin pc3++; r3 = $time; end
    always @(negedge g_clk0) if (!rst) chk("width0", longint'($time - r0), 5);
    always @(negedge g_clk3) if (!rst) chk("width3", longint'($time - r3), 5);

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_g_clk0", longint'(g_clk0), 0);
        chk("rst_g_clk3", longint'(g_clk3), 0);
        chk("rst_cnt3", longint'(cnt3), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        en = 1'b0;
        s0 = pc0; s3 = pc3;
        for (int e = 2; e <= 12; e++) step(e >= 3 && e <= 6, 1'b0);
        @(posedge clk);
        #2;
        chk("en3to6_pulses0", pc0 - s0, 4);
        chk("en3to6_pulses3", pc3 - s3, 7);
        chk("en3to6_cnt0", longint'(cnt0), 8);
        chk("en3to6_cnt3", longint'(cnt3), 5);
        s0 = pc0; s3 = pc3;
        for (int e = 13; e <= 19; e++) step(e == 14, 1'b0);
        @(posedge clk);
        #2;
        chk("hold_pulses0", pc0 - s0, 1);
        chk("hold_pulses3", pc3 - s3, 4);
        chk("hold_cnt0", longint'(cnt0), 14);
        chk("hold_cnt3", longint'(cnt3), 8);
        for (int i = 0; i < 6; i++) begin
            step(1'(i), 1'b0);
            @(posedge clk);
            #2;
            en = ~en;
            test_en = ~test_en;
        end
        step(1'b0, 1'b1);
        s0 = pc0; s3 = pc3; c0s = int'(cnt0); c3s = int'(cnt3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        @(posedge clk);
        #2;
        chk("scan_pulses0", pc0 - s0, 5);
        chk("scan_pulses3", pc3 - s3, 5);
        chk("scan_open0", longint'(open0), 1);
        chk("scan_cnt0", longint'(cnt0), c0s);
        chk("scan_cnt3", longint'(cnt3), c3s);
        c0s = int'(cnt0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("sat_cnt3", longint'(cnt3), 15);
        chk("sat_cnt0", longint'(cnt0), c0s + 20);
        step(1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_g_clk3", longint'(g_clk3), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_g_clk0", longint'(g_clk0), 0);
        chk("mid_rst_g_clk3", longint'(g_clk3), 0);
        chk("mid_rst_open3", longint'(open3), 0);
        chk("mid_rst_cnt0", longint'(cnt0), 0);
        chk("mid_rst_cnt3", longint'(cnt3), 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            rst = 1'b0;
            en = ($urandom_range(0, 2) == 0);
            test_en = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #2;
            if ($urandom_range(0, 3) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) test_en = ~test_en;
            if ($urandom_range(0, 49) == 0) rst = 1'b1;
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #6;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
